// File: rtl/fifo_sync_lvl.sv
// Single-clock FIFO with fill level, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and optional first-word-fall-through.
module fifo_sync_lvl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_BITS  = 4,
  parameter int unsigned AFULL_THR  = 12,
  parameter int unsigned AEMPTY_THR = 4,
  parameter int unsigned FWFT       = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_BITS:0]    fill_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam int unsigned CNT_W = ADDR_BITS + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]  w_ptr;
  logic [ADDR_BITS-1:0]  r_ptr;
  logic                  wr_acc_c;
  logic                  rd_acc_c;
  logic [CNT_W-1:0]      count_nxt_c;

  // Acceptance is judged on the registered flags of the current cycle only.
  assign wr_acc_c = w_en & ~fifo_full;
  assign rd_acc_c = r_en & ~fifo_empty;

  always_comb begin
    count_nxt_c = fill_count;
    unique case ({wr_acc_c, rd_acc_c})
      2'b10:   count_nxt_c = fill_count + CNT_W'(1);
      2'b01:   count_nxt_c = fill_count - CNT_W'(1);
      default: count_nxt_c = fill_count;
    endcase
  end

  // Pointers, level and level-decoded flags; flags track the new level so they
  // always equal a decode of the registered fill_count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      fill_count   <= '0;
      fifo_full    <= 1'b0;
      fifo_empty   <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (wr_acc_c) w_ptr <= w_ptr + ADDR_BITS'(1);
      if (rd_acc_c) r_ptr <= r_ptr + ADDR_BITS'(1);
      fill_count   <= count_nxt_c;
      fifo_full    <= (count_nxt_c == CNT_W'(DEPTH));
      fifo_empty   <= (count_nxt_c == '0);
      almost_full  <= (count_nxt_c >= CNT_W'(AFULL_THR));
      almost_empty <= (count_nxt_c <= CNT_W'(AEMPTY_THR));
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (w_en & fifo_full)  | (overflow  & ~err_clr);
      underflow <= (r_en & fifo_empty) | (underflow & ~err_clr);
    end
  end

  // Storage is not reset; writes are suppressed while reset is held.
  always_ff @(posedge clk_i) begin
    if (wr_acc_c && !reset_i) mem[w_ptr] <= data_in;
  end

  generate
    if (FWFT == 0) begin : g_reg_read
      logic [DATA_WIDTH-1:0] dout_q;

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          dout_q <= '0;
        end else if (rd_acc_c) begin
          dout_q <= mem[r_ptr];
        end
      end

      assign data_out = dout_q;
    end else begin : g_fwft_read
      // Head word is presented straight from storage; meaningless while empty.
      assign data_out = mem[r_ptr];
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_lvl.sv
// Directed bench for fifo_sync_lvl: a registered-read and an FWFT instance
// share one stimulus stream, checked against a hand-built vector table.
module tb_fifo_sync_lvl;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       w_en = 1'b0;
  logic       r_en = 1'b0;
  logic       err_clr = 1'b0;

  logic [7:0] dout0, dout1;
  logic       full0, empty0, afull0, aempty0, ovf0, unf0;
  logic       full1, empty1, afull1, aempty1, ovf1, unf1;
  logic [4:0] fc0, fc1;

  int passed = 0;
  int total  = 0;

  always #5 clk_i = ~clk_i;

  fifo_sync_lvl #(.DATA_WIDTH(8), .ADDR_BITS(4), .AFULL_THR(12), .AEMPTY_THR(4), .FWFT(0)) dut0 (
    .clk_i(clk_i), .reset_i(reset_i), .data_in(data_in), .w_en(w_en), .r_en(r_en),
    .err_clr(err_clr), .data_out(dout0), .fifo_full(full0), .fifo_empty(empty0),
    .almost_full(afull0), .almost_empty(aempty0), .fill_count(fc0),
    .overflow(ovf0), .underflow(unf0)
  );

  fifo_sync_lvl #(.DATA_WIDTH(8), .ADDR_BITS(4), .AFULL_THR(12), .AEMPTY_THR(4), .FWFT(1)) dut1 (
    .clk_i(clk_i), .reset_i(reset_i), .data_in(data_in), .w_en(w_en), .r_en(r_en),
    .err_clr(err_clr), .data_out(dout1), .fifo_full(full1), .fifo_empty(empty1),
    .almost_full(afull1), .almost_empty(aempty1), .fill_count(fc1),
    .overflow(ovf1), .underflow(unf1)
  );

  typedef struct {
    string      nm;
    logic       rst, w, r, clr;
    logic [7:0] din;
    int         cnt;
    logic       ovf, unf;
    logic       c0;
    logic [7:0] d0;
    logic       c1;
    logic [7:0] d1;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input string nm, input logic rst, input logic w, input logic r,
                              input logic clr, input logic [7:0] din, input int cnt,
                              input logic ovf, input logic unf, input logic c0,
                              input logic [7:0] d0, input logic c1, input logic [7:0] d1);
    vec_t v;
    v.nm = nm; v.rst = rst; v.w = w; v.r = r; v.clr = clr; v.din = din; v.cnt = cnt;
    v.ovf = ovf; v.unf = unf; v.c0 = c0; v.d0 = d0; v.c1 = c1; v.d1 = d1;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
  endtask

  initial begin
    //  name           rst w  r  clr din    cnt ovf unf c0 d0     c1 d1
    add("reset",        1, 0, 0, 0, 8'h00, 0,  0,  0,  1, 8'h00, 0, 8'h00);
    add("reset",        1, 0, 0, 0, 8'h00, 0,  0,  0,  1, 8'h00, 0, 8'h00);
    add("fwft_wr",      0, 1, 0, 0, 8'hA5, 1,  0,  0,  1, 8'h00, 1, 8'hA5);
    add("fwft_rd",      0, 0, 1, 0, 8'h00, 0,  0,  0,  1, 8'hA5, 0, 8'h00);
    for (int i = 1; i <= 16; i++)
      add("fill",       0, 1, 0, 0, 8'(i), i,  0,  0,  1, 8'hA5, 1, 8'h01);
    add("ovf_wr",       0, 1, 0, 0, 8'hEE, 16, 1,  0,  1, 8'hA5, 1, 8'h01);
    for (int k = 1; k <= 16; k++)
      add("drain",      0, 0, 1, 0, 8'h00, 16 - k, 1, 0, 1, 8'(k), (k < 16), 8'(k + 1));
    add("clr_ovf",      0, 0, 0, 1, 8'h00, 0,  0,  0,  1, 8'h10, 0, 8'h00);
    add("rd_empty_wr",  0, 1, 1, 0, 8'h77, 1,  0,  1,  1, 8'h10, 1, 8'h77);
    add("clr_unf",      0, 0, 0, 1, 8'h00, 1,  0,  0,  1, 8'h10, 1, 8'h77);
    add("rd_last",      0, 0, 1, 0, 8'h00, 0,  0,  0,  1, 8'h77, 0, 8'h00);
    add("unf_set",      0, 0, 1, 0, 8'h00, 0,  0,  1,  1, 8'h77, 0, 8'h00);
    add("set_wins",     0, 0, 1, 1, 8'h00, 0,  0,  1,  1, 8'h77, 0, 8'h00);
    add("clr2",         0, 0, 0, 1, 8'h00, 0,  0,  0,  1, 8'h77, 0, 8'h00);
    for (int i = 0; i < 8; i++)
      add("fill8",      0, 1, 0, 0, 8'(8'h20 + i), i + 1, 0, 0, 1, 8'h77, 1, 8'h20);
    for (int i = 0; i < 40; i++)
      add("steady",     0, 1, 1, 0, 8'(8'h28 + i), 8, 0, 0, 1, 8'(8'h20 + i), 1, 8'(8'h21 + i));
    add("to10",         0, 1, 0, 0, 8'h50, 9,  0,  0,  1, 8'h47, 1, 8'h48);
    add("to10",         0, 1, 0, 0, 8'h51, 10, 0,  0,  1, 8'h47, 1, 8'h48);
    add("rst_mid",      1, 1, 0, 0, 8'h99, 0,  0,  0,  1, 8'h00, 0, 8'h00);
    add("post_rst_rd",  0, 0, 1, 0, 8'h00, 0,  0,  1,  1, 8'h00, 0, 8'h00);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk_i);
      reset_i = vq[i].rst; w_en = vq[i].w; r_en = vq[i].r;
      err_clr = vq[i].clr; data_in = vq[i].din;
      @(posedge clk_i);
      #1;
      chk({vq[i].nm, ".count"},  i, 32'(fc0),     32'(vq[i].cnt));
      chk({vq[i].nm, ".count1"}, i, 32'(fc1),     32'(vq[i].cnt));
      chk({vq[i].nm, ".empty"},  i, 32'(empty0),  32'(vq[i].cnt == 0));
      chk({vq[i].nm, ".full"},   i, 32'(full0),   32'(vq[i].cnt == 16));
      chk({vq[i].nm, ".afull"},  i, 32'(afull0),  32'(vq[i].cnt >= 12));
      chk({vq[i].nm, ".aempty"}, i, 32'(aempty0), 32'(vq[i].cnt <= 4));
      chk({vq[i].nm, ".empty1"}, i, 32'(empty1),  32'(vq[i].cnt == 0));
      chk({vq[i].nm, ".ovf"},    i, 32'(ovf0),    32'(vq[i].ovf));
      chk({vq[i].nm, ".unf"},    i, 32'(unf0),    32'(vq[i].unf));
      chk({vq[i].nm, ".unf1"},   i, 32'(unf1),    32'(vq[i].unf));
      if (vq[i].c0) chk({vq[i].nm, ".dout_reg"},  i, 32'(dout0), 32'(vq[i].d0));
      if (vq[i].c1) chk({vq[i].nm, ".dout_fwft"}, i, 32'(dout1), 32'(vq[i].d1));
    end

    // Flags must not react combinationally to a request before the edge.
    @(negedge clk_i);
    reset_i = 1'b0; r_en = 1'b0; err_clr = 1'b1; w_en = 1'b1; data_in = 8'h3C;
    #1;
    chk("no_comb.empty", 0, 32'(empty0), 32'd1);
    chk("no_comb.count", 0, 32'(fc0),    32'd0);
    @(posedge clk_i);
    #1;
    chk("late.count",     0, 32'(fc0),   32'd1);
    chk("late.empty",     0, 32'(empty0), 32'd0);
    chk("late.unf_clr",   0, 32'(unf0),  32'd0);
    chk("late.dout_fwft", 0, 32'(dout1), 32'h3C);
    @(negedge clk_i);
    w_en = 1'b0; err_clr = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
